// File: rtl/decade_chain_ctrl.sv
// Sequencing controller for a chain of cascaded BCD decade counter stages.
// Generates prescaled count ticks, ripple-gated per-digit enables, and a shadow BCD count.
module decade_chain_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   target,
    output logic [DIGITS-1:0]     digit_en,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  done,
    output logic                  overflow
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_r;
    logic [PW-1:0]         presc_r;
    logic [4*DIGITS-1:0]   bcd_r;
    logic                  running_r;
    logic                  done_r;
    logic                  overflow_r;

    logic                  tick_s;
    logic [DIGITS-1:0]     digit_en_s;
    logic [4*DIGITS-1:0]   next_bcd_s;
    logic                  all_nines_s;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        if (d == 4'd9) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    // A pending stop/clear/rst suppresses the tick so external stages never advance on a command edge.
    assign tick_s = (state_r == RUN) && (presc_r == PRESC_LAST) && !stop && !clear && !rst;

    // Ripple-carry enable chain and the post-tick BCD value.
    always_comb begin : chain_comb
        logic carry_v;
        carry_v     = tick_s;
        all_nines_s = 1'b1;
        digit_en_s  = {DIGITS{1'b0}};
        next_bcd_s  = bcd_r;
        for (int k = 0; k < DIGITS; k++) begin
            digit_en_s[k] = carry_v;
            if (carry_v) begin
                next_bcd_s[4*k +: 4] = bcd_inc(bcd_r[4*k +: 4]);
            end else begin
                next_bcd_s[4*k +: 4] = bcd_r[4*k +: 4];
            end
            carry_v     = carry_v && (bcd_r[4*k +: 4] == 4'd9);
            all_nines_s = all_nines_s && (bcd_r[4*k +: 4] == 4'd9);
        end
    end

    // Control FSM, prescaler, shadow count and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            presc_r    <= {PW{1'b0}};
            bcd_r      <= {(4*DIGITS){1'b0}};
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= 1'b0;
            if (clear) begin
                state_r   <= IDLE;
                presc_r   <= {PW{1'b0}};
                bcd_r     <= {(4*DIGITS){1'b0}};
                running_r <= 1'b0;
                done_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && !stop) begin
                            state_r   <= RUN;
                            presc_r   <= {PW{1'b0}};
                            running_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            // Prescaler holds so resume neither loses nor repeats a tick.
                            state_r   <= PAUSE;
                            running_r <= 1'b0;
                        end else begin
                            if (presc_r == PRESC_LAST) begin
                                presc_r <= {PW{1'b0}};
                            end else begin
                                presc_r <= presc_r + PW'(1);
                            end
                            if (tick_s) begin
                                bcd_r      <= next_bcd_s;
                                overflow_r <= all_nines_s;
                                if (next_bcd_s == target) begin
                                    state_r   <= DONE;
                                    running_r <= 1'b0;
                                    done_r    <= 1'b1;
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (start && !stop) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    default: begin
                        state_r   <= IDLE;
                        presc_r   <= {PW{1'b0}};
                        running_r <= 1'b0;
                        done_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digit_en = digit_en_s;
    assign bcd      = bcd_r;
    assign running  = running_r;
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Directed self-checking bench for decade_chain_ctrl using four differently parameterised instances.
module tb_decade_chain_ctrl;

    logic clk;
    int   tests_run;
    int   tests_failed;

    // Instance A: DIGITS=4, PRESCALE=1
    logic        a_rst, a_start, a_stop, a_clear;
    logic [15:0] a_target, a_bcd;
    logic [3:0]  a_en;
    logic        a_running, a_done, a_ovf;
    // Instance B: DIGITS=2, PRESCALE=2
    logic        b_rst, b_start, b_stop, b_clear;
    logic [7:0]  b_target, b_bcd;
    logic [1:0]  b_en;
    logic        b_running, b_done, b_ovf;
    // Instance C: DIGITS=4, PRESCALE=4
    logic        c_rst, c_start, c_stop, c_clear;
    logic [15:0] c_target, c_bcd;
    logic [3:0]  c_en;
    logic        c_running, c_done, c_ovf;
    // Instance D: DIGITS=2, PRESCALE=1
    logic        d_rst, d_start, d_stop, d_clear;
    logic [7:0]  d_target, d_bcd;
    logic [1:0]  d_en;
    logic        d_running, d_done, d_ovf;

    decade_chain_ctrl #(.DIGITS(4), .PRESCALE(1)) u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .stop(a_stop), .clear(a_clear),
        .target(a_target), .digit_en(a_en), .bcd(a_bcd), .running(a_running),
        .done(a_done), .overflow(a_ovf));
    decade_chain_ctrl #(.DIGITS(2), .PRESCALE(2)) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop), .clear(b_clear),
        .target(b_target), .digit_en(b_en), .bcd(b_bcd), .running(b_running),
        .done(b_done), .overflow(b_ovf));
    decade_chain_ctrl #(.DIGITS(4), .PRESCALE(4)) u_c (
        .clk(clk), .rst(c_rst), .start(c_start), .stop(c_stop), .clear(c_clear),
        .target(c_target), .digit_en(c_en), .bcd(c_bcd), .running(c_running),
        .done(c_done), .overflow(c_ovf));
    decade_chain_ctrl #(.DIGITS(2), .PRESCALE(1)) u_d (
        .clk(clk), .rst(d_rst), .start(d_start), .stop(d_stop), .clear(d_clear),
        .target(d_target), .digit_en(d_en), .bcd(d_bcd), .running(d_running),
        .done(d_done), .overflow(d_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {a_rst, b_rst, c_rst, d_rst} = 4'b1111;
        repeat (2) step();
        {a_rst, b_rst, c_rst, d_rst} = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++;
            if ({a_bcd, a_en, a_running, a_done, a_ovf} !== 23'h0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: got bcd=%h en=%b run=%b done=%b ovf=%b, want all 0",
                         i, a_bcd, a_en, a_running, a_done, a_ovf);
            end
        end
        tests_run++;
        if ({b_bcd, b_en, b_running, b_done, b_ovf, c_bcd, c_en, d_bcd, d_en} !== 45'h0) begin
            tests_failed++;
            $display("FAIL reset_others: got b_bcd=%h c_bcd=%h d_bcd=%h, want 0", b_bcd, c_bcd, d_bcd);
        end
    endtask

    task automatic test_basic_count();
        logic [7:0] exp8;
        logic [1:0] exp_en;
        int cnt;
        b_target = 8'h99;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        tests_run++;
        if (b_running !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_running: got %b want 1", b_running);
        end
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tests_run++;
            if (b_en !== 2'b00) begin
                tests_failed++;
                $display("FAIL basic_en_idle tick %0d: got %b want 00", t, b_en);
            end
            step();
            exp_en = (t == 9) ? 2'b11 : 2'b01;
            tests_run++;
            if (b_en !== exp_en) begin
                tests_failed++;
                $display("FAIL basic_en_tick %0d: got %b want %b", t, b_en, exp_en);
            end
            step();
            cnt++;
            exp8 = {4'(cnt / 10), 4'(cnt % 10)};
            tests_run++;
            if (b_bcd !== exp8) begin
                tests_failed++;
                $display("FAIL basic_bcd tick %0d: got %h want %h", t, b_bcd, exp8);
            end
        end
        tests_run++;
        if (b_en !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_en_after_carry: got %b want 00", b_en);
        end
        b_stop = 1'b1;
        step();
        b_stop = 1'b0;
    endtask

    task automatic test_target_stop();
        a_target = 16'h0012;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (a_en[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL target_tick %0d: got en=%b want en[0]=1", i, a_en);
            end
            step();
        end
        tests_run++;
        if ({a_bcd, a_done, a_running} !== {16'h0012, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL target_done: got bcd=%h done=%b run=%b want 0012/1/0", a_bcd, a_done, a_running);
        end
        for (int i = 0; i < 10; i++) begin
            a_start = 1'b1;
            #1;
            tests_run++;
            if (a_en !== 4'b0000) begin
                tests_failed++;
                $display("FAIL target_en_hold %0d: got %b want 0000", i, a_en);
            end
            step();
            tests_run++;
            if ({a_bcd, a_done, a_running} !== {16'h0012, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL target_hold %0d: got bcd=%h done=%b run=%b", i, a_bcd, a_done, a_running);
            end
        end
        a_start = 1'b0;
    endtask

    task automatic test_clear_mid_run();
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        tests_run++;
        if ({a_bcd, a_done, a_running} !== 18'h0) begin
            tests_failed++;
            $display("FAIL clear_from_done: got bcd=%h done=%b run=%b want 0", a_bcd, a_done, a_running);
        end
        a_target = 16'hFFFF;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (357) step();
        tests_run++;
        if ({a_bcd, a_running} !== {16'h0357, 1'b1}) begin
            tests_failed++;
            $display("FAIL clear_precount: got bcd=%h run=%b want 0357/1", a_bcd, a_running);
        end
        a_clear = 1'b1;
        #1;
        tests_run++;
        if (a_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clear_gates_tick: got %b want 0000", a_en);
        end
        step();
        a_clear = 1'b0;
        tests_run++;
        if ({a_bcd, a_running, a_done} !== 18'h0) begin
            tests_failed++;
            $display("FAIL clear_mid_run: got bcd=%h run=%b done=%b want 0", a_bcd, a_running, a_done);
        end
        step();
        tests_run++;
        if ({a_bcd, a_en, a_running} !== 21'h0) begin
            tests_failed++;
            $display("FAIL clear_stays_idle: got bcd=%h en=%b run=%b", a_bcd, a_en, a_running);
        end
        a_target = 16'h0003;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (3) step();
        tests_run++;
        if ({a_bcd, a_done} !== {16'h0003, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_pre_done: got bcd=%h done=%b want 0003/1", a_bcd, a_done);
        end
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        tests_run++;
        if ({a_bcd, a_en, a_running, a_done, a_ovf} !== 23'h0) begin
            tests_failed++;
            $display("FAIL rst_in_done: got bcd=%h en=%b run=%b done=%b ovf=%b want 0",
                     a_bcd, a_en, a_running, a_done, a_ovf);
        end
    endtask

    task automatic test_pause_resume();
        c_target = 16'hFFFF;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        repeat (2) step();
        c_stop = 1'b1;
        #1;
        tests_run++;
        if (c_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL pause_stop_en: got %b want 0000", c_en);
        end
        step();
        c_stop = 1'b0;
        tests_run++;
        if (c_running !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_running: got %b want 0", c_running);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if ({c_bcd, c_en} !== 20'h0) begin
                tests_failed++;
                $display("FAIL pause_frozen %0d: got bcd=%h en=%b want 0", i, c_bcd, c_en);
            end
        end
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        tests_run++;
        if ({c_running, c_en} !== {1'b1, 4'b0000}) begin
            tests_failed++;
            $display("FAIL resume_first: got run=%b en=%b want 1/0000", c_running, c_en);
        end
        step();
        tests_run++;
        if (c_en !== 4'b0001) begin
            tests_failed++;
            $display("FAIL resume_tick: got %b want 0001", c_en);
        end
        step();
        tests_run++;
        if (c_bcd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL resume_bcd: got %h want 0001", c_bcd);
        end
        c_start = 1'b1;
        c_stop = 1'b1;
        step();
        c_start = 1'b0;
        c_stop = 1'b0;
        tests_run++;
        if ({c_running, c_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL overlap_stop_wins: got run=%b done=%b want 0/0", c_running, c_done);
        end
        repeat (5) step();
        tests_run++;
        if (c_bcd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL overlap_frozen: got %h want 0001", c_bcd);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp8;
        int ovf_count;
        d_target = 8'hAA;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        ovf_count = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            exp8 = {4'((i % 100) / 10), 4'(i % 10)};
            if (d_ovf === 1'b1) ovf_count++;
            tests_run++;
            if ({d_bcd, d_ovf} !== {exp8, (i == 100)}) begin
                tests_failed++;
                $display("FAIL ovf_run tick %0d: got bcd=%h ovf=%b want %h/%b", i, d_bcd, d_ovf, exp8, (i == 100));
            end
        end
        tests_run++;
        if (ovf_count !== 1) begin
            tests_failed++;
            $display("FAIL ovf_count: got %0d want 1", ovf_count);
        end
        step();
        tests_run++;
        if ({d_bcd, d_ovf, d_running} !== {8'h01, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovf_continue: got bcd=%h ovf=%b run=%b want 01/0/1", d_bcd, d_ovf, d_running);
        end
        d_clear = 1'b1;
        step();
        d_clear = 1'b0;
        d_target = 8'h00;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        for (int i = 1; i < 100; i++) begin
            step();
            tests_run++;
            if (d_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_target_early tick %0d: got done=%b want 0", i, d_done);
            end
        end
        step();
        tests_run++;
        if ({d_done, d_ovf, d_running, d_bcd} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL zero_target_wrap: got done=%b ovf=%b run=%b bcd=%h want 1/1/0/00",
                     d_done, d_ovf, d_running, d_bcd);
        end
        step();
        tests_run++;
        if ({d_done, d_ovf, d_bcd} !== {1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL zero_target_after: got done=%b ovf=%b bcd=%h want 1/0/00", d_done, d_ovf, d_bcd);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        {a_rst, b_rst, c_rst, d_rst}         = 4'b1111;
        {a_start, b_start, c_start, d_start} = 4'b0000;
        {a_stop, b_stop, c_stop, d_stop}     = 4'b0000;
        {a_clear, b_clear, c_clear, d_clear} = 4'b0000;
        a_target = 16'hFFFF;
        b_target = 8'hFF;
        c_target = 16'hFFFF;
        d_target = 8'hFF;
        test_reset();
        test_basic_count();
        test_target_stop();
        test_clear_mid_run();
        test_pause_resume();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decade_chain_ctrl.md
Name: decade_chain_ctrl

Overview:
Sequencing controller for a chain of cascaded decade (BCD 0-9) counter stages. It divides the system clock into count ticks and issues per-digit count enables with ripple-carry gating, so external decade counters advance in lockstep with an internal shadow BCD value. It also provides start/stop/clear control, target-match stop, and overflow reporting. It sits between the board-level control inputs and the decade counter datapath, and feeds display logic.

Parameters:
DIGITS, 4, number of cascaded decade stages; digit 0 is least significant.
PRESCALE, 10, clk cycles per count tick; must be >= 1; 1 = tick every cycle while running.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  level-sampled; begin or resume counting.
stop  input  1  level-sampled; pause counting.
clear  input  1  level-sampled; zero the count and return to IDLE.
target  input  4*DIGITS  BCD compare value; nibble k is digit k.
digit_en  output  DIGITS  per-digit count enable; one-cycle pulse per tick.
bcd  output  4*DIGITS  shadow count; nibble k is digit k.
running  output  1  high while in state RUN.
done  output  1  high while in state DONE.
overflow  output  1  one-cycle pulse when the chain wraps from all 9s to all 0s.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, prescaler=0, bcd=0. Resulting outputs: digit_en=0, running=0, done=0, overflow=0. Reset takes priority over every other input, including mid-count.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority, sampled every edge: rst > clear > stop > start.
- clear, from any state: bcd=0, prescaler=0, next state=IDLE, done drops.
- IDLE: start -> RUN with prescaler=0.
- RUN:
  - stop -> PAUSE; prescaler value retained.
  - start while already in RUN has no effect.
- PAUSE: start -> RUN; resumes from the retained prescaler value, so no tick is lost or duplicated.
- DONE: start and stop are ignored; only clear or rst leave DONE.
- start and stop asserted in the same cycle: stop wins.
- Prescaler and tick:
  - In RUN, the prescaler counts 0..PRESCALE-1 and wraps.
  - tick = (state==RUN) and (prescaler==PRESCALE-1) and not stop/clear/rst in that cycle.
  - First tick occurs PRESCALE cycles after entering RUN from IDLE.
- digit_en (combinational from registered state and tick):
  - digit_en[0] = tick.
  - digit_en[k] = digit_en[k-1] and (bcd digit k-1 == 9).
  - External stages see the enable during the same cycle and advance on the same edge as bcd.
- bcd update on a tick edge: each enabled digit increments; a digit equal to 9 wraps to 0. Disabled digits hold.
- overflow: registered one-cycle pulse the cycle after a tick edge at which all digits were 9; bcd becomes all 0.
- Target match:
  - Checked only on tick edges, against the post-increment value.
  - If next bcd == target: next state=DONE, running=0, done=1.
  - bcd holds at target; digit_en stays 0 thereafter.
- Non-BCD target (any nibble > 9): never matches; the chain counts and wraps indefinitely.
- target == 0: counting starts from 0 with no immediate match. The match fires on the wrap from all 9s, and overflow pulses in that same cycle that done rises.
- target is sampled live. Changing target mid-run affects only subsequent ticks.
- Outputs running, done, overflow and bcd are registered. digit_en is the only combinational output.

Test Plan:
- Reset/idle: rst high 2 cycles, then idle 20 cycles with no start -> bcd=0, digit_en=0, running=0, done=0, overflow=0 throughout.
- Basic count, PRESCALE=2, DIGITS=2, target=8'h99 (so no match before the wrap):
  - start 1 cycle -> digit_en[0] pulses every 2nd cycle; bcd 00,01,...,09,10.
  - At the 09->10 tick, digit_en=2'b11 for exactly 1 cycle.
- Target stop, PRESCALE=1, target=16'h0012 -> after 12 ticks bcd=0012, done=1, running=0; digit_en stays 0 for 10 further cycles; start ignored.
- Pause/resume, PRESCALE=4:
  - stop when prescaler=2, hold 6 cycles -> bcd frozen.
  - start -> next tick exactly 2 cycles later.
  - Overlap check: start+stop together while in RUN -> PAUSE.
- Overflow, DIGITS=2, PRESCALE=1, target=8'hAA (never matches): run 100 ticks -> bcd=00, overflow high exactly 1 cycle, counting continues. With target=8'h00, same run -> done=1 and overflow pulse in the same cycle.
- Clear mid-run: at bcd=0357, clear -> next cycle bcd=0, state IDLE, running=0. rst asserted during DONE -> all outputs return to reset values next cycle.
